// File: rtl/cpsd_pkg.sv
// Shared definitions for the beat-feature datapath: default sizes,
// the window state encoding and helpers that derive port widths.
package cpsd_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_LEN    = 256;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_WAIT_LOW = 2'd2
    } beat_state_t;

    // Width of the sample counter; must hold the value max_len itself.
    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // Width of the energy accumulator: one full square plus growth for
    // max_len additions, so it can never wrap.
    function automatic int acc_width(input int data_width, input int max_len);
        return 2 * data_width + 2 + $clog2(max_len);
    endfunction

endpackage

// File: rtl/sv_diff_sq.sv
// Combinational difference, magnitude and square of two signed samples.
// Everything is widened by one bit first, so no result can overflow.
module sv_diff_sq
    import cpsd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   vx,
    input  logic [DATA_WIDTH-1:0]   vy,
    output logic [DATA_WIDTH:0]     abs_val,
    output logic [2*DATA_WIDTH+1:0] sq
);

    localparam int SQ_W = 2 * DATA_WIDTH + 2;

    logic signed [DATA_WIDTH:0] vx_ext;
    logic signed [DATA_WIDTH:0] vy_ext;
    logic signed [DATA_WIDTH:0] diff;
    logic signed [DATA_WIDTH:0] diff_neg;
    logic        [SQ_W-1:0]     abs_wide;

    assign vx_ext   = {vx[DATA_WIDTH-1], vx};
    assign vy_ext   = {vy[DATA_WIDTH-1], vy};
    assign diff     = vx_ext - vy_ext;
    assign diff_neg = -diff;

    // |diff| is at most 2^DATA_WIDTH - 1, so it fits unsigned in DATA_WIDTH+1 bits.
    assign abs_val  = diff[DATA_WIDTH] ? $unsigned(diff_neg) : $unsigned(diff);
    assign abs_wide = {{(SQ_W - DATA_WIDTH - 1){1'b0}}, abs_val};
    assign sq       = abs_wide * abs_wide;

endmodule

// File: rtl/sv_beat_feature.sv
// Per-beat feature extractor: while the QRS flag is high it accumulates
// the peak |vx-vy|, the energy sum (vx-vy)^2 and the sample count, then
// publishes them with a one-cycle feat_valid pulse.
module sv_beat_feature
    import cpsd_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_LEN    = DEF_MAX_LEN,
    localparam int LEN_W      = len_width(MAX_LEN),
    localparam int ACC_W      = acc_width(DATA_WIDTH, MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] vx,
    input  logic [DATA_WIDTH-1:0] vy,
    input  logic                  qrs,
    output logic                  feat_valid,
    output logic [DATA_WIDTH:0]   peak_abs,
    output logic [ACC_W-1:0]      energy,
    output logic [LEN_W-1:0]      beat_len,
    output logic                  truncated
);

    localparam int SQ_W = 2 * DATA_WIDTH + 2;

    beat_state_t           state_reg;
    logic                  last_qrs_reg;
    logic [DATA_WIDTH:0]   peak_acc_reg;
    logic [ACC_W-1:0]      energy_acc_reg;
    logic [LEN_W-1:0]      len_reg;
    logic                  done_reg;
    logic                  trunc_pend_reg;

    logic [DATA_WIDTH:0]   abs_val;
    logic [SQ_W-1:0]       sq;
    logic [ACC_W-1:0]      sq_ext;
    logic [LEN_W-1:0]      len_next;

    sv_diff_sq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_diff_sq (
        .vx      (vx),
        .vy      (vy),
        .abs_val (abs_val),
        .sq      (sq)
    );

    assign sq_ext   = {{(ACC_W - SQ_W){1'b0}}, sq};
    assign len_next = len_reg + LEN_W'(1);

    // Window FSM, accumulators and result registers. A terminating sample
    // raises done_reg; on the following edge the accumulators are copied to
    // the outputs and feat_valid pulses. That copy is independent of en, and
    // a start sample on the same edge may safely reload the accumulators
    // because the copy reads their pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            last_qrs_reg   <= 1'b0;
            peak_acc_reg   <= '0;
            energy_acc_reg <= '0;
            len_reg        <= '0;
            done_reg       <= 1'b0;
            trunc_pend_reg <= 1'b0;
            feat_valid     <= 1'b0;
            peak_abs       <= '0;
            energy         <= '0;
            beat_len       <= '0;
            truncated      <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            feat_valid <= done_reg;
            if (done_reg) begin
                peak_abs  <= peak_acc_reg;
                energy    <= energy_acc_reg;
                beat_len  <= len_reg;
                truncated <= trunc_pend_reg;
            end

            if (en) begin
                last_qrs_reg <= qrs;
                case (state_reg)
                    ST_IDLE: begin
                        // Only a rising QRS edge opens a window.
                        if (qrs && !last_qrs_reg) begin
                            state_reg      <= ST_ACCUM;
                            peak_acc_reg   <= abs_val;
                            energy_acc_reg <= sq_ext;
                            len_reg        <= LEN_W'(1);
                        end
                    end
                    ST_ACCUM: begin
                        if (qrs) begin
                            energy_acc_reg <= energy_acc_reg + sq_ext;
                            if (abs_val > peak_acc_reg) begin
                                peak_acc_reg <= abs_val;
                            end
                            len_reg <= len_next;
                            // Window full: close it with this sample included.
                            if (len_next == LEN_W'(MAX_LEN)) begin
                                done_reg       <= 1'b1;
                                trunc_pend_reg <= 1'b1;
                                state_reg      <= ST_WAIT_LOW;
                            end
                        end else begin
                            // QRS fell: this sample is not part of the window.
                            done_reg       <= 1'b1;
                            trunc_pend_reg <= 1'b0;
                            state_reg      <= ST_IDLE;
                        end
                    end
                    ST_WAIT_LOW: begin
                        // Swallow the rest of an over-long QRS region.
                        if (!qrs) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sv_beat_feature.sv
// Scoreboard bench for sv_beat_feature: one instance with default sizing
// and one with MAX_LEN=4 for the truncation case. Expected results are
// queued as each window is driven and popped when feat_valid pulses.
module tb_sv_beat_feature;

    typedef struct {
        logic [63:0] peak;
        logic [63:0] energy;
        logic [63:0] len;
        logic [63:0] trunc;
    } exp_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        qrs  = 1'b0;
    logic [15:0] vx   = '0;
    logic [15:0] vy   = '0;

    logic        fv_a;
    logic [16:0] peak_a;
    logic [41:0] energy_a;
    logic [8:0]  len_a;
    logic        trunc_a;

    logic        fv_b;
    logic [16:0] peak_b;
    logic [35:0] energy_b;
    logic [2:0]  len_b;
    logic        trunc_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sel_b = 1'b0;

    sv_beat_feature #(
        .DATA_WIDTH (16),
        .MAX_LEN    (256)
    ) dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en_a),
        .vx         (vx),
        .vy         (vy),
        .qrs        (qrs),
        .feat_valid (fv_a),
        .peak_abs   (peak_a),
        .energy     (energy_a),
        .beat_len   (len_a),
        .truncated  (trunc_a)
    );

    sv_beat_feature #(
        .DATA_WIDTH (16),
        .MAX_LEN    (4)
    ) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en_b),
        .vx         (vx),
        .vy         (vy),
        .qrs        (qrs),
        .feat_valid (fv_b),
        .peak_abs   (peak_b),
        .energy     (energy_b),
        .beat_len   (len_b),
        .truncated  (trunc_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [63:0] p, input logic [63:0] e, input logic [63:0] l, input logic [63:0] t);
        exp_t x;
        x.peak = p; x.energy = e; x.len = l; x.trunc = t;
        q_a.push_back(x);
    endtask

    task automatic push_b(input logic [63:0] p, input logic [63:0] e, input logic [63:0] l, input logic [63:0] t);
        exp_t x;
        x.peak = p; x.energy = e; x.len = l; x.trunc = t;
        q_b.push_back(x);
    endtask

    // One clock with the given sample presented to the selected instance.
    task automatic smp(input int x, input int y, input bit q, input bit e);
        vx   = x[15:0];
        vy   = y[15:0];
        qrs  = q;
        en_a = e && !sel_b;
        en_b = e && sel_b;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        en_a = 1'b0;
        en_b = 1'b0;
        qrs  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string who, input logic fv, input logic [63:0] p,
                            input logic [63:0] e, input logic [63:0] l, input logic t);
        chk({who, "_rst_valid"},  {63'd0, fv}, 64'd0);
        chk({who, "_rst_peak"},   p, 64'd0);
        chk({who, "_rst_energy"}, e, 64'd0);
        chk({who, "_rst_len"},    l, 64'd0);
        chk({who, "_rst_trunc"},  {63'd0, t}, 64'd0);
    endtask

    // Scoreboard for the default instance: every pulse must match the head entry.
    always @(negedge clk) begin
        exp_t x;
        if (fv_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                x = q_a.pop_front();
                $display("a pulse: peak=%0d energy=%0d len=%0d trunc=%0d", peak_a, energy_a, len_a, trunc_a);
                chk("a_peak",   {47'd0, peak_a},   x.peak);
                chk("a_energy", {22'd0, energy_a}, x.energy);
                chk("a_len",    {55'd0, len_a},    x.len);
                chk("a_trunc",  {63'd0, trunc_a},  x.trunc);
            end
        end
    end

    // Scoreboard for the MAX_LEN=4 instance.
    always @(negedge clk) begin
        exp_t x;
        if (fv_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                x = q_b.pop_front();
                $display("b pulse: peak=%0d energy=%0d len=%0d trunc=%0d", peak_b, energy_b, len_b, trunc_b);
                chk("b_peak",   {47'd0, peak_b},   x.peak);
                chk("b_energy", {28'd0, energy_b}, x.energy);
                chk("b_len",    {61'd0, len_b},    x.len);
                chk("b_trunc",  {63'd0, trunc_b},  x.trunc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[5];
        int ys[5];

        // Reset state
        #2;
        chk_zero("a", fv_a, {47'd0, peak_a}, {22'd0, energy_a}, {55'd0, len_a}, trunc_a);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Basic window: diff 6 for three samples
        push_a(6, 108, 3, 0);
        smp(10, 4, 0, 1);
        repeat (3) smp(10, 4, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);

        // Extreme negative difference
        push_a(65535, 64'd4294836225, 1, 0);
        smp(-32768, 32767, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);

        // Both extremes: energy exceeds 32 bits
        push_a(65535, 64'd8589672450, 2, 0);
        smp(32767, -32768, 1, 1);
        smp(-32768, 32767, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);

        // Mixed signs: diffs 3, -7, 2
        push_a(7, 62, 3, 0);
        smp(5, 2, 1, 1);
        smp(-3, 4, 1, 1);
        smp(0, -2, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);

        // en toggling; idle cycles carry junk with qrs=0 that must be ignored
        xs = '{1, 0, 7, -1, 4};
        ys = '{0, 3, 2, 1, 4};
        push_a(5, 39, 5, 0);
        for (int i = 0; i < 5; i++) begin
            smp(xs[i], ys[i], 1, 1);
            smp(99, -99, 0, 0);
        end
        smp(0, 0, 0, 1);
        gap(3);

        // Back-to-back: new start lands on the same edge as the pulse
        push_a(2, 4, 1, 0);
        push_a(3, 13, 2, 0);
        smp(2, 0, 1, 1);
        smp(0, 0, 0, 1);
        smp(3, 0, 1, 1);
        smp(3, 1, 1, 1);
        smp(0, 0, 0, 1);
        gap(4);
        chk("a_hold_peak",   {47'd0, peak_a},   64'd3);
        chk("a_hold_energy", {22'd0, energy_a}, 64'd13);
        chk("a_hold_len",    {55'd0, len_a},    64'd2);
        chk("a_hold_valid",  {63'd0, fv_a},     64'd0);

        // Truncation on MAX_LEN=4; first accepted sample after reset is a start
        sel_b = 1'b1;
        push_b(1, 4, 4, 1);
        repeat (10) smp(1, 0, 1, 1);
        smp(0, 0, 0, 1);
        push_b(1, 2, 2, 0);
        smp(-1, 0, 1, 1);
        smp(-1, 0, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);
        chk("b_hold_trunc", {63'd0, trunc_b}, 64'd0);
        sel_b = 1'b0;

        // Reset mid-window: outputs clear at once, partial window discarded
        smp(0, 0, 0, 1);
        smp(5, 0, 1, 1);
        smp(5, 0, 1, 1);
        #1 rstn = 1'b0;
        #1;
        chk_zero("a", fv_a, {47'd0, peak_a}, {22'd0, energy_a}, {55'd0, len_a}, trunc_a);
        chk_zero("b", fv_b, {47'd0, peak_b}, {28'd0, energy_b}, {61'd0, len_b}, trunc_b);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        push_a(1, 3, 3, 0);
        repeat (3) smp(2, 1, 1, 1);
        smp(0, 0, 0, 1);
        gap(3);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
        chk("a_missing_pulses", 64'(q_a.size()), 64'd0);
        chk("b_missing_pulses", 64'(q_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
